fft_twiddle_gen: RTL and testbench

Streaming twiddle-factor generator for one radix-2 decimation-in-frequency (DIF) stage of the 64-point FFT. It sits directly upstream of the `mult` coefficient input (`inb`). It tracks the sample index of each incoming frame and emits the matching signed twiddle W^k = exp(-j2πk/64), quantised to TW_W bits. A valid/start-of-frame sideband is delay-matched so the data path can align samples to coefficients.

---
 rtl/fft_twiddle_gen_if.sv | 35 +++
 rtl/fft_twiddle_gen.sv | 189 ++++++++++++++++++
 tb/tb_fft_twiddle_gen.sv | 364 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_twiddle_gen_if.sv
// -----------------------------------------------------------------------------
// fft_twiddle_gen_if
// Sample-side handshake and twiddle-side outputs of the DIF twiddle generator.
//   in_valid  : one sample enters the stage this cycle
//   in_sop    : qualifies in_valid, marks sample 0 of a frame
//   tw_re     : signed real part of the twiddle (TW_W bits)
//   tw_im     : signed imaginary part of the twiddle (TW_W bits)
//   tw_valid  : tw_re/tw_im belong to an accepted sample
//   tw_sop    : delayed in_sop, aligned with tw_valid
//   tw_idx    : sample index n the twiddle belongs to
//   frame_err : one-cycle pulse when in_sop arrives at n != 0
// master drives the samples in; slave is the generator.
// -----------------------------------------------------------------------------
interface fft_twiddle_gen_if #(
  parameter int TW_W = 8
);
  logic                   in_valid;
  logic                   in_sop;
  logic signed [TW_W-1:0] tw_re;
  logic signed [TW_W-1:0] tw_im;
  logic                   tw_valid;
  logic                   tw_sop;
  logic [5:0]             tw_idx;
  logic                   frame_err;

  modport master (
    output in_valid, in_sop,
    input  tw_re, tw_im, tw_valid, tw_sop, tw_idx, frame_err
  );

  modport slave (
    input  in_valid, in_sop,
    output tw_re, tw_im, tw_valid, tw_sop, tw_idx, frame_err
  );
endinterface

// File: rtl/fft_twiddle_gen.sv
// -----------------------------------------------------------------------------
// fft_twiddle_gen
// Streaming twiddle generator for one radix-2 DIF stage of a 64-point FFT.
// Tracks the sample index n of each frame and emits W^k = exp(-j*2*pi*k/64)
// quantised to TW_W signed bits, with valid/sop/index/error sideband
// delay-matched to the coefficient.
// Parameters:
//   STAGE     : DIF stage 0..5, butterfly span L = 64 >> STAGE
//   TW_W      : twiddle width, full scale 2^(TW_W-1)-1
//   EXTRA_DLY : extra output register stages 0..4
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : fft_twiddle_gen_if slave (in_valid/in_sop in, tw_* / frame_err out)
// Latency in_valid -> tw_valid is 2 + EXTRA_DLY cycles.
// -----------------------------------------------------------------------------
module fft_twiddle_gen #(
  parameter int STAGE     = 0,
  parameter int TW_W      = 8,
  parameter int EXTRA_DLY = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  fft_twiddle_gen_if.slave  bus
);

  localparam int         SPAN  = 64 >> STAGE;
  localparam int         HALF  = SPAN / 2;
  localparam logic [5:0] MASK  = 6'(SPAN - 1);
  localparam logic [5:0] HALF6 = 6'(HALF);

  // cos(2*pi*i/64) scaled by 1e9; quantised at elaboration to any TW_W
  function automatic longint cos_e9(input int i);
    case (i)
      0:       return 64'd1000000000;
      1:       return 64'd995184727;
      2:       return 64'd980785280;
      3:       return 64'd956940336;
      4:       return 64'd923879533;
      5:       return 64'd881921264;
      6:       return 64'd831469612;
      7:       return 64'd773010453;
      8:       return 64'd707106781;
      9:       return 64'd634393284;
      10:      return 64'd555570233;
      11:      return 64'd471396737;
      12:      return 64'd382683432;
      13:      return 64'd290284677;
      14:      return 64'd195090322;
      15:      return 64'd98017140;
      default: return 64'd0;
    endcase
  endfunction

  // All table entries are non-negative, so +0.5 then truncate is
  // round-half-away-from-zero.
  function automatic logic signed [TW_W-1:0] quant(input int i);
    longint fs;
    longint q;
    fs = (longint'(1) << (TW_W - 1)) - 64'sd1;
    q  = (fs * cos_e9(i) + 64'sd500000000) / 64'sd1000000000;
    return TW_W'(q);
  endfunction

  logic signed [TW_W-1:0] w_tab [0:16];

  genvar g;
  for (g = 0; g < 17; g++) begin : g_tab
    assign w_tab[g] = quant(g);
  end

  // ---------------------------------------------------------------------------
  // Stage 1: sample index, exponent and flags
  // ---------------------------------------------------------------------------
  logic [5:0] r_cnt;
  logic [5:0] r_n1;
  logic [4:0] r_k1;
  logic       r_v1;
  logic       r_sop1;
  logic       r_err1;

  logic [5:0] w_n;
  logic [5:0] w_m;
  logic [5:0] w_diff;
  logic [4:0] w_k;

  // Lower half of each butterfly span uses W^0; the upper half steps the
  // exponent by 2^STAGE, which never exceeds 31.
  always_comb begin
    w_n    = bus.in_sop ? 6'd0 : r_cnt;
    w_m    = w_n & MASK;
    w_diff = w_m - HALF6;
    if (w_m < HALF6) w_k = 5'd0;
    else             w_k = 5'(w_diff << STAGE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= 6'd0;
      r_n1   <= 6'd0;
      r_k1   <= 5'd0;
      r_v1   <= 1'b0;
      r_sop1 <= 1'b0;
      r_err1 <= 1'b0;
    end else begin
      r_v1   <= bus.in_valid;
      r_sop1 <= bus.in_valid & bus.in_sop;
      r_err1 <= bus.in_valid & bus.in_sop & (r_cnt != 6'd0);
      if (bus.in_valid) begin
        r_cnt <= bus.in_sop ? 6'd1 : r_cnt + 6'd1;
        r_n1  <= w_n;
        r_k1  <= w_k;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: quarter-wave lookup. For k > 16 the real part folds to
  // -c[32-k], and 32-k in 5 bits is simply -k.
  // ---------------------------------------------------------------------------
  logic                   w_upper;
  logic [4:0]             w_reIdx;
  logic [4:0]             w_imIdx;
  logic signed [TW_W-1:0] w_re;
  logic signed [TW_W-1:0] w_im;

  always_comb begin
    w_upper = (r_k1 > 5'd16);
    if (!w_upper) begin
      w_reIdx = r_k1;
      w_imIdx = 5'd16 - r_k1;
    end else begin
      w_reIdx = 5'd0 - r_k1;
      w_imIdx = r_k1 - 5'd16;
    end
    w_re = w_upper ? -w_tab[w_reIdx] : w_tab[w_reIdx];
    w_im = -w_tab[w_imIdx];
  end

  // Index 0 is stage 2; indices 1..EXTRA_DLY are the latency-matching
  // stages. Data registers only load with a valid sample so the outputs
  // hold their last value across gaps.
  logic signed [TW_W-1:0] r_re  [0:EXTRA_DLY];
  logic signed [TW_W-1:0] r_im  [0:EXTRA_DLY];
  logic [5:0]             r_idx [0:EXTRA_DLY];
  logic                   r_vld [0:EXTRA_DLY];
  logic                   r_sop [0:EXTRA_DLY];
  logic                   r_err [0:EXTRA_DLY];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int e = 0; e <= EXTRA_DLY; e++) begin
        r_re[e]  <= '0;
        r_im[e]  <= '0;
        r_idx[e] <= 6'd0;
        r_vld[e] <= 1'b0;
        r_sop[e] <= 1'b0;
        r_err[e] <= 1'b0;
      end
    end else begin
      r_vld[0] <= r_v1;
      r_sop[0] <= r_sop1;
      r_err[0] <= r_err1;
      if (r_v1) begin
        r_re[0]  <= w_re;
        r_im[0]  <= w_im;
        r_idx[0] <= r_n1;
      end
      for (int e = 1; e <= EXTRA_DLY; e++) begin
        r_vld[e] <= r_vld[e-1];
        r_sop[e] <= r_sop[e-1];
        r_err[e] <= r_err[e-1];
        if (r_vld[e-1]) begin
          r_re[e]  <= r_re[e-1];
          r_im[e]  <= r_im[e-1];
          r_idx[e] <= r_idx[e-1];
        end
      end
    end
  end

  assign bus.tw_re     = r_re[EXTRA_DLY];
  assign bus.tw_im     = r_im[EXTRA_DLY];
  assign bus.tw_idx    = r_idx[EXTRA_DLY];
  assign bus.tw_valid  = r_vld[EXTRA_DLY];
  assign bus.tw_sop    = r_sop[EXTRA_DLY];
  assign bus.frame_err = r_err[EXTRA_DLY];

endmodule

// File: tb/tb_fft_twiddle_gen.sv
// -----------------------------------------------------------------------------
// tb_fft_twiddle_gen
// Drives four generators (STAGE 0, 3, 5 with no extra delay, and STAGE 3 with
// EXTRA_DLY = 2) from one sample stream and compares every output every cycle
// against a reference built from the twiddle definition exp(-j*2*pi*k/64).
// -----------------------------------------------------------------------------
module tb_fft_twiddle_gen;

  logic clk = 1'b0;
  logic rst_n;
  logic tbValid;
  logic tbSop;

  always #5 clk = ~clk;

  fft_twiddle_gen_if #(.TW_W(8)) if0 ();
  fft_twiddle_gen_if #(.TW_W(8)) if1 ();
  fft_twiddle_gen_if #(.TW_W(8)) if2 ();
  fft_twiddle_gen_if #(.TW_W(8)) if3 ();

  assign if0.in_valid = tbValid;
  assign if0.in_sop   = tbSop;
  assign if1.in_valid = tbValid;
  assign if1.in_sop   = tbSop;
  assign if2.in_valid = tbValid;
  assign if2.in_sop   = tbSop;
  assign if3.in_valid = tbValid;
  assign if3.in_sop   = tbSop;

  fft_twiddle_gen #(.STAGE(0), .TW_W(8), .EXTRA_DLY(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  fft_twiddle_gen #(.STAGE(3), .TW_W(8), .EXTRA_DLY(0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  fft_twiddle_gen #(.STAGE(5), .TW_W(8), .EXTRA_DLY(0)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));
  fft_twiddle_gen #(.STAGE(3), .TW_W(8), .EXTRA_DLY(2)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));

  // {valid, sop, err, idx[5:0], re[7:0], im[7:0]}
  logic [24:0] obsPk [4];
  assign obsPk[0] = {if0.tw_valid, if0.tw_sop, if0.frame_err, if0.tw_idx, if0.tw_re, if0.tw_im};
  assign obsPk[1] = {if1.tw_valid, if1.tw_sop, if1.frame_err, if1.tw_idx, if1.tw_re, if1.tw_im};
  assign obsPk[2] = {if2.tw_valid, if2.tw_sop, if2.frame_err, if2.tw_idx, if2.tw_re, if2.tw_im};
  assign obsPk[3] = {if3.tw_valid, if3.tw_sop, if3.frame_err, if3.tw_idx, if3.tw_re, if3.tw_im};

  localparam int STAGE_OF [4] = '{0, 3, 5, 3};
  localparam int LAT_OF   [4] = '{1, 1, 1, 3};

  int checks     = 0;
  int failures   = 0;
  int cyc        = 0;
  int killBefore = 0;
  int cnt        = 0;

  bit          eV [4096];
  bit          eS [4096];
  bit          eE [4096];
  int          eN [4096];
  logic [24:0] expPk [4];
  int          heldN  [4];
  int          heldRe [4];
  int          heldIm [4];

  function automatic int rnd(input real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    else          return -$rtoi(-x + 0.5);
  endfunction

  function automatic void twid(input int stage, input int n, output int re, output int im);
    int  span;
    int  m;
    int  k;
    real th;
    span = 64 >> stage;
    m    = n % span;
    k    = (m < span / 2) ? 0 : (m - span / 2) << stage;
    th   = 2.0 * 3.14159265358979 * k / 64.0;
    re   = rnd(127.0 * $cos(th));
    im   = -rnd(127.0 * $sin(th));
  endfunction

  function automatic void computeExpect();
    int src;
    int re;
    int im;
    for (int j = 0; j < 4; j++) begin
      src = cyc - LAT_OF[j];
      if (src > 0 && src >= killBefore && eV[src]) begin
        twid(STAGE_OF[j], eN[src], re, im);
        heldN[j]  = eN[src];
        heldRe[j] = re;
        heldIm[j] = im;
        expPk[j]  = {1'b1, eS[src], eE[src], 6'(eN[src]), 8'(re), 8'(im)};
      end else begin
        expPk[j] = {3'b000, 6'(heldN[j]), 8'(heldRe[j]), 8'(heldIm[j])};
      end
    end
  endfunction

  task automatic applyStimulus(input logic v, input logic s);
    tbValid = v;
    tbSop   = s;
    @(posedge clk);
    cyc++;
    if (rst_n && v) begin
      eV[cyc] = 1'b1;
      eS[cyc] = s;
      if (s) begin
        eN[cyc] = 0;
        eE[cyc] = (cnt != 0);
        cnt     = 1;
      end else begin
        eN[cyc] = cnt;
        eE[cyc] = 1'b0;
        cnt     = (cnt + 1) % 64;
      end
    end else begin
      eV[cyc] = 1'b0;
      eS[cyc] = 1'b0;
      eE[cyc] = 1'b0;
      eN[cyc] = 0;
    end
    #1;
    computeExpect();
  endtask

  task automatic modelReset();
    killBefore = cyc + 1;
    cnt        = 0;
    for (int j = 0; j < 4; j++) begin
      heldN[j]  = 0;
      heldRe[j] = 0;
      heldIm[j] = 0;
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0);
      for (int j = 0; j < 4; j++) begin
        checks++;
        if (obsPk[j] !== 25'd0) begin
          failures++;
          $display("[TB] FAIL reset_zero dut%0d cyc=%0d got=%h exp=%h", j, cyc, obsPk[j], 25'd0);
        end
      end
    end
    rst_n = 1'b1;
    for (int i = 0; i < 64; i++) begin
      applyStimulus(1'b1, 1'b0);
      for (int j = 0; j < 4; j++) begin
        checks++;
        if (obsPk[j] !== expPk[j]) begin
          failures++;
          $display("[TB] FAIL reset_stream dut%0d cyc=%0d got=%h exp=%h", j, cyc, obsPk[j], expPk[j]);
        end
      end
      if (i == 0) begin
        checks++;
        if (obsPk[0][24] !== 1'b0) begin
          failures++;
          $display("[TB] FAIL first_latency_early got=%b exp=0", obsPk[0][24]);
        end
      end
      if (i == 1) begin
        checks++;
        if ({obsPk[0][24], obsPk[0][21:0]} !== {1'b1, 6'd0, 8'd127, 8'd0}) begin
          failures++;
          $display("[TB] FAIL first_sample got=%h exp=%h", {obsPk[0][24], obsPk[0][21:0]}, {1'b1, 6'd0, 8'd127, 8'd0});
        end
      end
    end
  endtask

  task automatic test_stage0_frame();
    for (int i = 0; i < 66; i++) begin
      applyStimulus(i < 64, i == 0);
      for (int j = 0; j < 4; j++) begin
        checks++;
        if (obsPk[j] !== expPk[j]) begin
          failures++;
          $display("[TB] FAIL stage0_frame dut%0d cyc=%0d got=%h exp=%h", j, cyc, obsPk[j], expPk[j]);
        end
      end
      if (obsPk[0][24] && (obsPk[0][21:16] < 6'd32 || obsPk[0][21:16] == 6'd40 ||
                           obsPk[0][21:16] == 6'd48 || obsPk[0][21:16] == 6'd56)) begin
        logic [15:0] want;
        case (obsPk[0][21:16])
          6'd40:   want = 16'h5AA6;
          6'd48:   want = 16'h0081;
          6'd56:   want = 16'hA6A6;
          default: want = 16'h7F00;
        endcase
        checks++;
        if (obsPk[0][15:0] !== want) begin
          failures++;
          $display("[TB] FAIL stage0_const n=%0d got=%h exp=%h", obsPk[0][21:16], obsPk[0][15:0], want);
        end
      end
    end
  endtask

  task automatic test_stage_spans();
    for (int i = 0; i < 68; i++) begin
      applyStimulus(i < 64, i == 0);
      for (int j = 0; j < 4; j++) begin
        checks++;
        if (obsPk[j] !== expPk[j]) begin
          failures++;
          $display("[TB] FAIL stage_spans dut%0d cyc=%0d got=%h exp=%h", j, cyc, obsPk[j], expPk[j]);
        end
      end
      for (int j = 1; j < 4; j += 2) begin
        if (obsPk[j][24] && obsPk[j][21:16] inside {6'd4, 6'd6, 6'd7, 6'd12}) begin
          logic [15:0] want;
          case (obsPk[j][21:16])
            6'd6:    want = 16'h0081;
            6'd7:    want = 16'hA6A6;
            default: want = 16'h7F00;
          endcase
          checks++;
          if (obsPk[j][15:0] !== want) begin
            failures++;
            $display("[TB] FAIL stage3_const dut%0d n=%0d got=%h exp=%h", j, obsPk[j][21:16], obsPk[j][15:0], want);
          end
        end
      end
      if (obsPk[2][24]) begin
        checks++;
        if (obsPk[2][15:0] !== 16'h7F00) begin
          failures++;
          $display("[TB] FAIL stage5_const n=%0d got=%h exp=%h", obsPk[2][21:16], obsPk[2][15:0], 16'h7F00);
        end
      end
    end
  endtask

  task automatic test_gaps();
    logic pattern [4];
    pattern = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 68; i++) begin
      applyStimulus(i < 64 ? pattern[i % 4] : 1'b0, i == 0);
      for (int j = 0; j < 4; j++) begin
        checks++;
        if (obsPk[j] !== expPk[j]) begin
          failures++;
          $display("[TB] FAIL gaps dut%0d cyc=%0d got=%h exp=%h", j, cyc, obsPk[j], expPk[j]);
        end
      end
    end
  endtask

  task automatic test_restart();
    for (int i = 0; i < 24; i++) begin
      applyStimulus(1'b1, (i == 0) || (i == 20));
      for (int j = 0; j < 4; j++) begin
        checks++;
        if (obsPk[j] !== expPk[j]) begin
          failures++;
          $display("[TB] FAIL restart dut%0d cyc=%0d got=%h exp=%h", j, cyc, obsPk[j], expPk[j]);
        end
      end
      if (i == 21 || i == 22) begin
        logic [7:0] want;
        want = (i == 21) ? {1'b1, 1'b1, 6'd0} : {1'b1, 1'b0, 6'd1};
        checks++;
        if ({obsPk[0][24], obsPk[0][22:16]} !== want) begin
          failures++;
          $display("[TB] FAIL restart_const step=%0d got=%h exp=%h", i, {obsPk[0][24], obsPk[0][22:16]}, want);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
      for (int j = 0; j < 4; j++) begin
        checks++;
        if (obsPk[j] !== expPk[j]) begin
          failures++;
          $display("[TB] FAIL random dut%0d cyc=%0d got=%h exp=%h", j, cyc, obsPk[j], expPk[j]);
        end
      end
    end
  endtask

  task automatic test_wrap_reset();
    for (int i = 0; i < 130; i++) begin
      applyStimulus(1'b1, i == 0);
      for (int j = 0; j < 4; j++) begin
        checks++;
        if (obsPk[j] !== expPk[j]) begin
          failures++;
          $display("[TB] FAIL wrap dut%0d cyc=%0d got=%h exp=%h", j, cyc, obsPk[j], expPk[j]);
        end
      end
      if (i >= 2) begin
        checks++;
        if (obsPk[0][22] !== 1'b0) begin
          failures++;
          $display("[TB] FAIL wrap_no_err cyc=%0d got=%b exp=0", cyc, obsPk[0][22]);
        end
      end
    end
    for (int i = 0; i < 64 && cnt != 38; i++) begin
      applyStimulus(1'b1, 1'b0);
    end
    rst_n = 1'b0;
    modelReset();
    #1;
    computeExpect();
    checks++;
    if (obsPk[0][24] !== 1'b0) begin
      failures++;
      $display("[TB] FAIL async_drop got=%b exp=0", obsPk[0][24]);
    end
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (obsPk[j] !== expPk[j]) begin
        failures++;
        $display("[TB] FAIL async_zero dut%0d got=%h exp=%h", j, obsPk[j], expPk[j]);
      end
    end
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(i < 3, 1'b0);
      for (int j = 0; j < 4; j++) begin
        checks++;
        if (obsPk[j] !== expPk[j]) begin
          failures++;
          $display("[TB] FAIL after_reset dut%0d cyc=%0d got=%h exp=%h", j, cyc, obsPk[j], expPk[j]);
        end
      end
      if (i == 1) begin
        checks++;
        if ({obsPk[0][24], obsPk[0][21:16]} !== {1'b1, 6'd0}) begin
          failures++;
          $display("[TB] FAIL after_reset_n0 got=%h exp=%h", {obsPk[0][24], obsPk[0][21:16]}, {1'b1, 6'd0});
        end
      end
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    tbValid = 1'b0;
    tbSop   = 1'b0;
    for (int j = 0; j < 4; j++) begin
      heldN[j]  = 0;
      heldRe[j] = 0;
      heldIm[j] = 0;
      expPk[j]  = 25'd0;
    end
    test_reset();
    test_stage0_frame();
    test_stage_spans();
    test_gaps();
    test_restart();
    test_random();
    test_wrap_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
